// File: rtl/impulse_analyzer_if.sv
`default_nettype none
// ============================================================================
// impulse_analyzer_if : control, buffer read port and result bus of the
//                       impulse analyzer
// Revision 1.0
// ============================================================================
interface impulse_analyzer_if;
  logic               start_in;
  logic        [15:0] threshold;
  logic        [15:0] read_addr;
  logic signed [15:0] read_data;
  logic               busy;
  logic               done;
  logic        [15:0] peak_amp;
  logic        [15:0] peak_index;
  logic        [15:0] onset_index;
  logic               onset_found;

  // master: the analyzer itself
  modport master (
    input  start_in, threshold, read_data,
    output read_addr, busy, done, peak_amp, peak_index, onset_index, onset_found
  );

  // slave: recorder / buffer / consumer side
  modport slave (
    output start_in, threshold, read_data,
    input  read_addr, busy, done, peak_amp, peak_index, onset_index, onset_found
  );
endinterface
`default_nettype wire

// File: rtl/impulse_analyzer.sv
`default_nettype none
// ============================================================================
// impulse_analyzer : one-pass scan of the impulse buffer for peak |x|, its
//                    index, and the first index whose |x| reaches a threshold
// Revision 1.0
// ============================================================================
module impulse_analyzer #(
  parameter int IMPULSE_LENGTH = 48000,
  parameter int READ_LATENCY   = 2
) (
  input logic                audio_clk,
  input logic                rst_in,
  impulse_analyzer_if.master bus
);

  localparam logic [15:0] C_LAST_ADDR = 16'(IMPULSE_LENGTH - 1);
  localparam logic [16:0] C_ABS_MAX   = 17'd32767;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_start_prev;
  logic [15:0]             r_thr;
  logic [READ_LATENCY-1:0] r_vld;
  logic [15:0]             r_idx [READ_LATENCY];
  logic [15:0]             r_wk_amp;
  logic [15:0]             r_wk_pidx;
  logic [15:0]             r_wk_oidx;
  logic                    r_wk_found;

  logic [READ_LATENCY-1:0] w_vld_nxt;
  logic [15:0]             w_wk_amp;
  logic [15:0]             w_wk_pidx;
  logic [15:0]             w_wk_oidx;
  logic                    w_wk_found;
  logic [16:0]             w_x17;
  logic [16:0]             w_abs17;
  logic [15:0]             w_abs;
  logic                    w_start_edge;
  logic                    w_finish;

  assign w_start_edge = bus.start_in & ~r_start_prev;

  always_comb begin
    w_vld_nxt    = '0;
    w_vld_nxt[0] = (r_state == S_SCAN);
    for (int i = 1; i < READ_LATENCY; i++) begin
      w_vld_nxt[i] = r_vld[i-1];
    end

    w_x17   = {bus.read_data[15], bus.read_data};
    w_abs17 = bus.read_data[15] ? (17'd0 - w_x17) : w_x17;
    w_abs   = (w_abs17 > C_ABS_MAX) ? 16'h7FFF : w_abs17[15:0];

    w_wk_amp   = r_wk_amp;
    w_wk_pidx  = r_wk_pidx;
    w_wk_oidx  = r_wk_oidx;
    w_wk_found = r_wk_found;
    if (r_vld[READ_LATENCY-1]) begin
      // strict compare so equal peaks keep the earliest index
      if (w_abs > r_wk_amp) begin
        w_wk_amp  = w_abs;
        w_wk_pidx = r_idx[READ_LATENCY-1];
      end
      if (!r_wk_found && (w_abs >= r_thr)) begin
        w_wk_found = 1'b1;
        w_wk_oidx  = r_idx[READ_LATENCY-1];
      end
    end

    // last sample sits in the final stage and nothing follows it
    w_finish = (r_state == S_DRAIN) && (w_vld_nxt == '0);
  end

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      r_state         <= S_IDLE;
      r_start_prev    <= 1'b0;
      r_thr           <= '0;
      r_vld           <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_idx[i] <= '0;
      end
      r_wk_amp        <= '0;
      r_wk_pidx       <= '0;
      r_wk_oidx       <= '0;
      r_wk_found      <= 1'b0;
      bus.read_addr   <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.peak_amp    <= '0;
      bus.peak_index  <= '0;
      bus.onset_index <= '0;
      bus.onset_found <= 1'b0;
    end else begin
      r_start_prev <= bus.start_in;
      r_vld        <= w_vld_nxt;
      r_idx[0]     <= bus.read_addr;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_idx[i] <= r_idx[i-1];
      end
      r_wk_amp   <= w_wk_amp;
      r_wk_pidx  <= w_wk_pidx;
      r_wk_oidx  <= w_wk_oidx;
      r_wk_found <= w_wk_found;
      bus.done   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          bus.read_addr <= '0;
          if (w_start_edge) begin
            r_thr      <= bus.threshold;
            r_wk_amp   <= '0;
            r_wk_pidx  <= '0;
            r_wk_oidx  <= '0;
            r_wk_found <= 1'b0;
            bus.busy   <= 1'b1;
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (bus.read_addr == C_LAST_ADDR) begin
            r_state <= S_DRAIN;
          end else begin
            bus.read_addr <= bus.read_addr + 16'd1;
          end
        end
        S_DRAIN: begin
          if (w_finish) begin
            bus.peak_amp    <= w_wk_amp;
            bus.peak_index  <= w_wk_pidx;
            bus.onset_index <= w_wk_oidx;
            bus.onset_found <= w_wk_found;
            bus.done        <= 1'b1;
            bus.busy        <= 1'b0;
            bus.read_addr   <= '0;
            r_state         <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_impulse_analyzer.sv
`default_nettype none
// ============================================================================
// tb_impulse_analyzer : directed vector bench with a 2-cycle BRAM model
// Revision 1.0
// ============================================================================
module tb_impulse_analyzer;

  localparam int L = 8;
  localparam int R = 2;

  typedef struct {
    logic [L-1:0][15:0] smp;
    logic [15:0]        thr;
    logic [15:0]        e_amp;
    logic [15:0]        e_pidx;
    logic [15:0]        e_oidx;
    logic               e_found;
    int                 repulse;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  impulse_analyzer_if bus ();

  impulse_analyzer #(
    .IMPULSE_LENGTH (L),
    .READ_LATENCY   (R)
  ) dut (
    .audio_clk (clk),
    .rst_in    (rst),
    .bus       (bus)
  );

  logic signed [15:0] mem [L];
  logic signed [15:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= mem[bus.read_addr[2:0]];
    rd2 <= rd1;
  end
  assign bus.read_data = rd2;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vec [6];
  logic [15:0] p_amp, p_pidx, p_oidx;
  logic        p_found;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int s0, input int s1, input int s2, input int s3,
                              input int s4, input int s5, input int s6, input int s7,
                              input int thr, input int amp, input int pidx,
                              input int oidx, input int found, input int rep);
    vec_t v;
    v.smp[0] = 16'(s0); v.smp[1] = 16'(s1); v.smp[2] = 16'(s2); v.smp[3] = 16'(s3);
    v.smp[4] = 16'(s4); v.smp[5] = 16'(s5); v.smp[6] = 16'(s6); v.smp[7] = 16'(s7);
    v.thr     = 16'(thr);
    v.e_amp   = 16'(amp);
    v.e_pidx  = 16'(pidx);
    v.e_oidx  = 16'(oidx);
    v.e_found = found[0];
    v.repulse = rep;
    return v;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < L; i++) mem[i] = v.smp[i];
    bus.threshold = v.thr;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_done"},  32'(bus.done), 0);
    chk({tag, "_addr"},  32'(bus.read_addr), 0);
    chk({tag, "_amp"},   32'(bus.peak_amp), 0);
    chk({tag, "_pidx"},  32'(bus.peak_index), 0);
    chk({tag, "_oidx"},  32'(bus.onset_index), 0);
    chk({tag, "_found"}, 32'(bus.onset_found), 0);
  endtask

  // Called in the cycle whose closing edge sees the start edge; next negedge is T0.
  task automatic check_scan(input vec_t v);
    for (int c = 0; c <= L + R + 1; c++) begin
      @(negedge clk);
      if (c == 1) bus.threshold = ~v.thr;
      if (v.repulse >= 0) begin
        if (c == v.repulse - 1) bus.start_in = 1'b0;
        if (c == v.repulse)     bus.start_in = 1'b1;
      end
      if (c < L)          chk("read_addr", 32'(bus.read_addr), 32'(c));
      else if (c < L + R) chk("read_addr_hold", 32'(bus.read_addr), L - 1);
      else                chk("read_addr_idle", 32'(bus.read_addr), 0);
      if (c < L + R) begin
        chk("busy_scan", 32'(bus.busy), 1);
        chk("done_early", 32'(bus.done), 0);
        if (c == 5) begin
          chk("hold_amp",   32'(bus.peak_amp),    32'(p_amp));
          chk("hold_pidx",  32'(bus.peak_index),  32'(p_pidx));
          chk("hold_oidx",  32'(bus.onset_index), 32'(p_oidx));
          chk("hold_found", 32'(bus.onset_found), 32'(p_found));
        end
      end else if (c == L + R) begin
        chk("done_pulse", 32'(bus.done), 1);
        chk("busy_drop",  32'(bus.busy), 0);
        chk("peak_amp",    32'(bus.peak_amp),    32'(v.e_amp));
        chk("peak_index",  32'(bus.peak_index),  32'(v.e_pidx));
        chk("onset_index", 32'(bus.onset_index), 32'(v.e_oidx));
        chk("onset_found", 32'(bus.onset_found), 32'(v.e_found));
      end else begin
        chk("done_single", 32'(bus.done), 0);
      end
    end
    p_amp = v.e_amp; p_pidx = v.e_pidx; p_oidx = v.e_oidx; p_found = v.e_found;
  endtask

  task automatic run_scan(input vec_t v);
    load(v);
    @(negedge clk) bus.start_in = 1'b0;
    @(negedge clk) bus.start_in = 1'b1;
    check_scan(v);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.done) n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    vec[0] = mk(0, 3, -7, 100, -200, 5, 0, 1,         50,    200,   4, 3, 1, -1);
    vec[1] = mk(10, -10, 10, 0, 0, 0, 0, 0,           11,    10,    0, 0, 0, -1);
    vec[2] = mk(0, 0, 0, 0, 0, 0, -32768, 0,          32767, 32767, 6, 6, 1, -1);
    vec[3] = mk(0, 0, 0, 0, 0, 0, 0, 0,               0,     0,     0, 0, 1, 3);
    vec[4] = mk(5, -300, 300, 299, -301, 0, 0, 32767, 301,   32767, 7, 4, 1, -1);
    vec[5] = mk(-1, -2, -3, -4, -5, -6, -7, -8,       8,     8,     7, 7, 1, -1);

    rst = 1'b1;
    bus.start_in = 1'b0;
    bus.threshold = '0;
    for (int i = 0; i < L; i++) mem[i] = '0;
    p_amp = '0; p_pidx = '0; p_oidx = '0; p_found = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    for (int v = 0; v < 6; v++) run_scan(vec[v]);

    // start held high after a completed scan must not retrigger
    count_dones(50, n);
    chk("held_start_dones", 32'(n), 0);
    run_scan(vec[0]);

    // reset mid-scan at T0+4
    load(vec[4]);
    @(negedge clk) bus.start_in = 1'b0;
    @(negedge clk) bus.start_in = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus.start_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("abort");
    count_dones(15, n);
    chk("abort_no_done", 32'(n), 0);
    p_amp = '0; p_pidx = '0; p_oidx = '0; p_found = 1'b0;
    run_scan(vec[0]);

    // start already high as reset releases counts as an edge
    load(vec[1]);
    @(negedge clk);
    rst = 1'b1;
    bus.start_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    p_amp = '0; p_pidx = '0; p_oidx = '0; p_found = 1'b0;
    check_scan(vec[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/impulse_analyzer.md
Name: impulse_analyzer

Overview:
- Post-capture analysis stage; consumes the impulse-response buffer written by the impulse recorder.
- On a rising edge of the recorder's `impulse_recorded` flag, scans the buffer once through its read port.
- Reports the peak absolute amplitude and its index, plus the first index at or above a programmable onset threshold.
- The onset index is the measured acoustic delay and feeds back into the recorder's `delay_length` and the convolution setup.

Parameters:
- impulse_length, 48000, number of buffer samples scanned (addresses 0..impulse_length-1).
- read_latency, 2, cycles from read_addr presented to read_data valid (BRAM with output register); legal range 1..4.

Ports:
- audio_clk  input  1  single system clock; all logic on posedge.
- rst_in  input  1  synchronous reset, active-high.
- start_in  input  1  driven by the recorder's impulse_recorded (a level); scan starts on its 0->1 transition only.
- threshold  input  16  unsigned onset threshold, compared against |sample|; sampled once when the scan starts.
- read_addr  output  16  buffer read address.
- read_data  input  16  signed buffer sample, valid read_latency cycles after the address.
- busy  output  1  high from the first SCAN cycle through the last DRAIN cycle.
- done  output  1  one-cycle pulse when results update.
- peak_amp  output  16  unsigned max |sample| of the last completed scan.
- peak_index  output  16  address of peak_amp.
- onset_index  output  16  first address with |sample| >= threshold.
- onset_found  output  1  high if any sample met the threshold.

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE.
  - The start edge detector's previous-value register is cleared to 0, so start_in already high when reset releases counts as an edge.
  - Reset mid-scan aborts immediately; results are cleared and no done pulse is produced.
- IDLE:
  - read_addr is held at 0.
  - On a start_in rising edge: latch threshold, clear working accumulators, go to SCAN.
- SCAN:
  - Let T0 be the first SCAN cycle. read_addr equals k in cycle T0+k, for k = 0..impulse_length-1.
  - After presenting impulse_length-1, go to DRAIN; read_addr holds its last value.
- Sample pipeline:
  - A valid/index shift register of depth read_latency tracks issued addresses.
  - read_data for address k is consumed in cycle T0+k+read_latency.
- DRAIN:
  - Waits until the valid pipeline is empty.
  - In cycle T0+impulse_length+read_latency: copy working results to the outputs, pulse done for 1 cycle, drop busy, return to IDLE.
- Per-sample arithmetic:
  - abs = (x<0) ? -x : x, computed in 17 bits then saturated to 16 bits; -32768 maps to 32767.
  - Peak update only when abs > working peak (strict), so ties keep the earliest index.
  - The working peak starts at 0 with index 0, so an all-zero buffer gives peak_amp=0, peak_index=0.
  - Onset: the first sample with abs >= latched threshold sets onset_index and onset_found; later samples do not change them.
  - threshold=0 gives onset_index=0, onset_found=1.
  - No qualifying sample gives onset_found=0, onset_index=0.
- Output holding:
  - peak_amp, peak_index, onset_index and onset_found hold the previous scan's values while busy; they change only in the done cycle.
- Start handling:
  - A start edge while busy is ignored; no queueing.
  - start_in held high does not retrigger.
  - A new edge (low, then high) after done begins a fresh scan.
- Timing:
  - Fixed: start-edge cycle + 1 + impulse_length + read_latency cycles to done.
  - No back-pressure; read_data is trusted every cycle.

Test Plan (impulse_length=8, read_latency=2, bench BRAM model with 2-cycle latency):
- Buffer [0,3,-7,100,-200,5,0,1], threshold=50, start 0->1 -> read_addr 0..7 on consecutive cycles; done exactly 10 cycles after T0; peak_amp=200, peak_index=4, onset_index=3, onset_found=1.
- Buffer [10,-10,10,0,0,0,0,0], threshold=11 -> peak_amp=10, peak_index=0 (tie keeps earliest), onset_found=0, onset_index=0.
- Buffer with -32768 at index 6, others 0, threshold=32767 -> peak_amp=32767, peak_index=6, onset_index=6, onset_found=1.
- start_in held high for 50 cycles after one scan -> exactly one done pulse; then start_in low 1 cycle, high again -> second scan runs, outputs hold the prior values until the second done.
- rst_in asserted for 1 cycle at T0+4 -> next cycle all outputs 0, busy=0, no done pulse; a subsequent start edge completes normally.
- threshold=0, all-zero buffer; also a start edge pulsed again at T0+3 -> single done; peak_amp=0, peak_index=0, onset_index=0, onset_found=1.
